// File: rtl/dmac_pkg.sv
// dmac_chain shared definitions: register offsets,
// engine state encoding and STATUS bit positions.
package dmac_pkg;

  localparam logic [3:0] REG_START  = 4'h0;
  localparam logic [3:0] REG_INTR   = 4'h1;
  localparam logic [3:0] REG_INT_EN = 4'h2;
  localparam logic [3:0] REG_SRC    = 4'h3;
  localparam logic [3:0] REG_DST    = 4'h4;
  localparam logic [3:0] REG_SIZE   = 4'h5;
  localparam logic [3:0] REG_PUSH   = 4'h6;
  localparam logic [3:0] REG_COUNT  = 4'h7;
  localparam logic [3:0] REG_ABORT  = 4'h8;
  localparam logic [3:0] REG_STATUS = 4'h9;

  localparam int ST_BUSY  = 0;
  localparam int ST_PERR  = 1;
  localparam int ST_ABRT  = 2;
  localparam int ST_FULL  = 3;
  localparam int ST_EMPTY = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_RD,
    S_CAP,
    S_WR,
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/dmac_desc_fifo.sv
// Descriptor FIFO: push/pop/flush with count; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module dmac_desc_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full, wr_ptr aliases rd_ptr; the popped entry has
  // already been read this cycle, so overwriting it is safe.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmac_chain.sv
// Descriptor-chained DMA controller: slave register port
// queues descriptors; master port copies them word by word.
module dmac_chain
  import dmac_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int SIZE_W     = 16,
  parameter int DESC_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              s_interrupt,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_address,
  input  logic [DATA_W-1:0] m_din,
  output logic [DATA_W-1:0] m_dout
);

  localparam int FW   = 2*ADDR_W + SIZE_W;
  localparam int CW   = $clog2(DESC_DEPTH) + 1;
  localparam int STEP = DATA_W / 8;

  state_e            state, state_n;
  logic [ADDR_W-1:0] src, src_n;
  logic [ADDR_W-1:0] dst, dst_n;
  logic [SIZE_W-1:0] rem, rem_n;
  logic [DATA_W-1:0] bbuf, bbuf_n;

  logic [ADDR_W-1:0] src_stg;
  logic [ADDR_W-1:0] dst_stg;
  logic [SIZE_W-1:0] size_stg;
  logic              intr;
  logic              int_en;
  logic              push_err;
  logic              aborted;
  logic              abort_pend;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [FW-1:0]     fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  logic [ADDR_W-1:0] hd_src;
  logic [ADDR_W-1:0] hd_dst;
  logic [SIZE_W-1:0] hd_size;

  logic              dec;
  logic [3:0]        off;
  logic              wr_reg;
  logic              rd_reg;
  logic              busy;
  logic              start_ok;
  logic [4:0]        status;
  logic [DATA_W-1:0] rdata;

  logic              unused_bits;

  assign unused_bits = ^s_din;

  assign dec    = (s_address[ADDR_W-1:4] == '0);
  assign off    = s_address[3:0];
  assign wr_reg = s_sel & s_wr & dec;
  assign rd_reg = s_sel & ~s_wr;
  assign busy   = (state != S_IDLE);

  assign start_ok = wr_reg && (off == REG_START) && s_din[0]
                    && !busy && !fifo_empty;

  assign fifo_push = wr_reg && (off == REG_PUSH);

  assign hd_src  = fifo_dout[FW-1 -: ADDR_W];
  assign hd_dst  = fifo_dout[SIZE_W +: ADDR_W];
  assign hd_size = fifo_dout[SIZE_W-1:0];

  assign status = {fifo_empty, fifo_full, aborted, push_err, busy};

  assign s_interrupt = intr & int_en;

  dmac_desc_fifo #(
    .W     (FW),
    .DEPTH (DESC_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   ({src_stg, dst_stg, size_stg}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Abort is honoured only where a new beat would begin,
  // so a read is never left without its write.
  always_comb begin
    state_n    = state;
    src_n      = src;
    dst_n      = dst;
    rem_n      = rem;
    bbuf_n     = bbuf;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_ok) state_n = S_POP;
      end
      S_POP: begin
        fifo_pop = 1'b1;
        src_n    = hd_src;
        dst_n    = hd_dst;
        rem_n    = hd_size;
        if (hd_size == '0) begin
          state_n = S_NEXT;
        end else if (abort_pend) begin
          fifo_flush = 1'b1;
          state_n    = S_DONE;
        end else begin
          state_n = S_RD;
        end
      end
      S_RD: begin
        if (m_grant) state_n = S_CAP;
      end
      S_CAP: begin
        bbuf_n  = m_din;
        state_n = S_WR;
      end
      S_WR: begin
        if (m_grant) begin
          src_n = src + ADDR_W'(STEP);
          dst_n = dst + ADDR_W'(STEP);
          rem_n = rem - 1'b1;
          if (rem_n == '0) begin
            state_n = S_NEXT;
          end else if (abort_pend) begin
            fifo_flush = 1'b1;
            state_n    = S_DONE;
          end else begin
            state_n = S_RD;
          end
        end
      end
      S_NEXT: begin
        if (abort_pend) begin
          fifo_flush = 1'b1;
          state_n    = S_DONE;
        end else if (!fifo_empty) begin
          state_n = S_POP;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      src       <= '0;
      dst       <= '0;
      rem       <= '0;
      bbuf      <= '0;
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_address <= '0;
      m_dout    <= '0;
    end else begin
      state <= state_n;
      src   <= src_n;
      dst   <= dst_n;
      rem   <= rem_n;
      bbuf  <= bbuf_n;
      m_req <= (state_n == S_RD) || (state_n == S_CAP)
               || (state_n == S_WR);
      m_wr  <= (state_n == S_WR);
      unique case (state_n)
        S_RD, S_CAP: m_address <= src_n;
        S_WR:        m_address <= dst_n;
        default:     m_address <= '0;
      endcase
      m_dout <= (state_n == S_WR) ? bbuf_n : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_stg    <= '0;
      dst_stg    <= '0;
      size_stg   <= '0;
      intr       <= 1'b0;
      int_en     <= 1'b0;
      push_err   <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (wr_reg && off == REG_SRC)    src_stg  <= s_din[ADDR_W-1:0];
      if (wr_reg && off == REG_DST)    dst_stg  <= s_din[ADDR_W-1:0];
      if (wr_reg && off == REG_SIZE)   size_stg <= s_din[SIZE_W-1:0];
      if (wr_reg && off == REG_INT_EN) int_en   <= s_din[0];

      if (state == S_DONE)
        intr <= 1'b1;
      else if (wr_reg && off == REG_INTR && s_din[0])
        intr <= 1'b0;

      if (fifo_push && fifo_full && !fifo_pop && !fifo_flush)
        push_err <= 1'b1;
      else if (wr_reg && off == REG_STATUS)
        push_err <= 1'b0;

      if (fifo_flush)
        aborted <= 1'b1;
      else if (wr_reg && off == REG_STATUS)
        aborted <= 1'b0;

      if (fifo_flush || state == S_DONE)
        abort_pend <= 1'b0;
      else if (wr_reg && off == REG_ABORT && s_din[0] && busy)
        abort_pend <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (dec) begin
      unique case (1'b1)
        off == REG_INTR:   rdata = DATA_W'(intr);
        off == REG_INT_EN: rdata = DATA_W'(int_en);
        off == REG_SRC:    rdata = DATA_W'(src_stg);
        off == REG_DST:    rdata = DATA_W'(dst_stg);
        off == REG_SIZE:   rdata = DATA_W'(size_stg);
        off == REG_COUNT:  rdata = DATA_W'(fifo_count);
        off == REG_STATUS: rdata = DATA_W'(status);
        default:           rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       s_dout <= '0;
    else if (rd_reg) s_dout <= rdata;
  end

endmodule

// File: tb/tb_dmac_chain.sv
// Directed bench for dmac_chain: register port, chained
// transfers, stall, abort and mid-transfer reset.
module tb_dmac_chain;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_address;
  logic [31:0] s_din;
  logic [31:0] s_dout;
  logic        s_interrupt;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic [15:0] m_address;
  logic [31:0] m_din;
  logic [31:0] m_dout;

  logic        din_pat;
  logic [31:0] din_fix;

  int n_cmp = 0;
  int n_bad = 0;
  int req_cnt = 0;
  logic rd_hold = 1'b0;

  logic [15:0] rq[$];
  logic [15:0] wa[$];
  logic [31:0] wd[$];

  always #5 clk = ~clk;

  always_comb m_din = din_pat ? {16'hBEEF, m_address} : din_fix;

  dmac_chain dut (
    .clk         (clk),
    .reset       (reset),
    .s_sel       (s_sel),
    .s_wr        (s_wr),
    .s_address   (s_address),
    .s_din       (s_din),
    .s_dout      (s_dout),
    .s_interrupt (s_interrupt),
    .m_req       (m_req),
    .m_grant     (m_grant),
    .m_wr        (m_wr),
    .m_address   (m_address),
    .m_din       (m_din),
    .m_dout      (m_dout)
  );

  // bus monitor: one read per RD grant, one write per WR grant
  always @(negedge clk) begin
    #1;
    if (m_req) req_cnt++;
    if (m_req && m_grant && !m_wr) begin
      if (!rd_hold) rq.push_back(m_address);
      rd_hold = 1'b1;
    end else begin
      rd_hold = 1'b0;
    end
    if (m_req && m_grant && m_wr) begin
      wa.push_back(m_address);
      wd.push_back(m_dout);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    s_sel = 1'b1;
    s_wr = 1'b1;
    s_address = a;
    s_din = d;
    @(negedge clk);
    s_sel = 1'b0;
    s_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    s_sel = 1'b1;
    s_wr = 1'b0;
    s_address = a;
    @(negedge clk);
    s_sel = 1'b0;
    d = s_dout;
  endtask

  task automatic clr_log();
    rq.delete();
    wa.delete();
    wd.delete();
    req_cnt = 0;
  endtask

  task automatic wait_int(output int n);
    n = 0;
    while (!s_interrupt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("int_seen", 32'(s_interrupt), 32'd1);
  endtask

  task automatic push(input logic [15:0] sa, input logic [15:0] da,
                      input logic [15:0] sz);
    bus_wr(16'h3, 32'(sa));
    bus_wr(16'h4, 32'(da));
    bus_wr(16'h5, 32'(sz));
    bus_wr(16'h6, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    int k;
    logic bad_a, bad_d, bad_w;

    reset = 1'b1;
    s_sel = 1'b0;
    s_wr = 1'b0;
    s_address = '0;
    s_din = '0;
    m_grant = 1'b1;
    din_pat = 1'b0;
    din_fix = 32'h12345678;
    repeat (2) @(negedge clk);
    chk("rst_sdout", s_dout, 32'h0);
    chk("rst_mreq", 32'(m_req), 32'h0);
    chk("rst_mwr", 32'(m_wr), 32'h0);
    chk("rst_maddr", 32'(m_address), 32'h0);
    chk("rst_mdout", m_dout, 32'h0);
    chk("rst_int", 32'(s_interrupt), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    bus_rd(16'h9, d);
    chk("rst_status", d, 32'h10);
    bus_rd(16'h7, d);
    chk("rst_count", d, 32'h0);

    // single-word transfer, interrupt masked
    push(16'h0200, 16'h0300, 16'h1);
    bus_rd(16'h7, d);
    chk("t1_count", d, 32'h1);
    clr_log();
    bus_wr(16'h0, 32'h1);
    repeat (10) @(negedge clk);
    chk("t1_nrd", 32'(rq.size()), 32'd1);
    chk("t1_nwr", 32'(wa.size()), 32'd1);
    if (rq.size() > 0) chk("t1_rdaddr", 32'(rq[0]), 32'h0200);
    if (wa.size() > 0) begin
      chk("t1_wraddr", 32'(wa[0]), 32'h0300);
      chk("t1_wrdata", wd[0], 32'h12345678);
    end
    chk("t1_masked", 32'(s_interrupt), 32'h0);
    bus_rd(16'h1, d);
    chk("t1_intr", d, 32'h1);
    bus_wr(16'h2, 32'h1);
    chk("t1_irq", 32'(s_interrupt), 32'h1);
    bus_wr(16'h1, 32'h1);
    chk("t1_irqclr", 32'(s_interrupt), 32'h0);
    bus_rd(16'h10, d);
    chk("t1_undec", d, 32'h0);

    // four-word transfer, 3N+3 samples from POP to irq
    din_pat = 1'b1;
    push(16'h0200, 16'h0300, 16'h4);
    clr_log();
    bus_wr(16'h0, 32'h1);
    wait_int(n);
    chk("t2_cycles", 32'(n), 32'd15);
    chk("t2_reqcyc", 32'(req_cnt), 32'd12);
    chk("t2_nrd", 32'(rq.size()), 32'd4);
    chk("t2_nwr", 32'(wa.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rq.size())
        chk("t2_rdaddr", 32'(rq[i]), 32'h0200 + 32'(4*i));
      if (i < wa.size()) begin
        chk("t2_wraddr", 32'(wa[i]), 32'h0300 + 32'(4*i));
        chk("t2_wrdata", wd[i], 32'hBEEF0200 + 32'(4*i));
      end
    end
    bus_wr(16'h1, 32'h1);

    // overfill the FIFO, then run all 16
    bus_wr(16'h5, 32'h1);
    for (int i = 0; i < 17; i++) begin
      bus_wr(16'h3, 32'h1000 + 32'(16*i));
      bus_wr(16'h4, 32'h2000 + 32'(16*i));
      bus_wr(16'h6, 32'h0);
    end
    bus_rd(16'h7, d);
    chk("t3_count", d, 32'd16);
    bus_rd(16'h9, d);
    chk("t3_status", d, 32'h0A);
    clr_log();
    bus_wr(16'h0, 32'h1);
    wait_int(n);
    chk("t3_cycles", 32'(n), 32'd81);
    chk("t3_nwr", 32'(wa.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < wa.size()) begin
        chk("t3_wraddr", 32'(wa[i]), 32'h2000 + 32'(16*i));
        chk("t3_wrdata", wd[i], 32'hBEEF1000 + 32'(16*i));
      end
    end
    bus_rd(16'h7, d);
    chk("t3_count0", d, 32'd0);
    bus_rd(16'h9, d);
    chk("t3_status2", d, 32'h12);
    bus_wr(16'h9, 32'h0);
    bus_rd(16'h9, d);
    chk("t3_stclr", d, 32'h10);
    bus_wr(16'h1, 32'h1);

    // grant stall during WR
    push(16'h0400, 16'h0500, 16'h1);
    clr_log();
    bus_wr(16'h0, 32'h1);
    k = 0;
    while (!m_wr && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t4_wrseen", 32'(m_wr), 32'h1);
    m_grant = 1'b0;
    bad_a = 1'b0;
    bad_d = 1'b0;
    bad_w = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m_address !== 16'h0500) bad_a = 1'b1;
      if (m_dout !== 32'hBEEF0400) bad_d = 1'b1;
      if (m_wr !== 1'b1 || m_req !== 1'b1) bad_w = 1'b1;
    end
    chk("t4_addr_stable", 32'(bad_a), 32'h0);
    chk("t4_dout_stable", 32'(bad_d), 32'h0);
    chk("t4_wr_stable", 32'(bad_w), 32'h0);
    m_grant = 1'b1;
    wait_int(n);
    chk("t4_reqcyc", 32'(req_cnt), 32'd8);
    chk("t4_nwr", 32'(wa.size()), 32'd1);
    bus_wr(16'h1, 32'h1);

    // abort during beat 2 with 3 descriptors queued
    push(16'h0600, 16'h0700, 16'h4);
    push(16'h0800, 16'h0900, 16'h2);
    push(16'h0800, 16'h0900, 16'h2);
    bus_rd(16'h7, d);
    chk("t5_count3", d, 32'd3);
    clr_log();
    bus_wr(16'h0, 32'h1);
    k = 0;
    while (!(m_req && !m_wr && m_address == 16'h0604) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t5_beat2", 32'(m_address), 32'h0604);
    bus_wr(16'h8, 32'h1);
    wait_int(n);
    chk("t5_nrd", 32'(rq.size()), 32'd2);
    chk("t5_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() > 1) begin
      chk("t5_wraddr", 32'(wa[1]), 32'h0704);
      chk("t5_wrdata", wd[1], 32'hBEEF0604);
    end
    bus_rd(16'h9, d);
    chk("t5_status", d, 32'h14);
    bus_rd(16'h7, d);
    chk("t5_count0", d, 32'd0);
    bus_rd(16'h1, d);
    chk("t5_intr", d, 32'h1);

    // reset while in RD
    bus_wr(16'h9, 32'h0);
    push(16'h0A00, 16'h0B00, 16'h2);
    bus_wr(16'h0, 32'h1);
    k = 0;
    while (!m_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t6_rdseen", 32'(m_req), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_mreq", 32'(m_req), 32'h0);
    chk("t6_maddr", 32'(m_address), 32'h0);
    reset = 1'b0;
    clr_log();
    bus_rd(16'h9, d);
    chk("t6_status", d, 32'h10);
    bus_rd(16'h3, d);
    chk("t6_src", d, 32'h0);
    bus_rd(16'h1, d);
    chk("t6_intr", d, 32'h0);
    bus_wr(16'h0, 32'h1);
    bus_rd(16'h9, d);
    chk("t6_nostart", d, 32'h10);
    repeat (5) @(negedge clk);
    chk("t6_quiet", 32'(req_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
